// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: active-low segment patterns
// (bit6 = a ... bit0 = g), recovered symbol codes and anode helpers.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SYM_W      = 5;

  localparam logic [6:0] SEG_0       = 7'h01;
  localparam logic [6:0] SEG_1       = 7'h4F;
  localparam logic [6:0] SEG_2       = 7'h12;
  localparam logic [6:0] SEG_3       = 7'h06;
  localparam logic [6:0] SEG_4       = 7'h4C;
  localparam logic [6:0] SEG_5       = 7'h24;
  localparam logic [6:0] SEG_6       = 7'h20;
  localparam logic [6:0] SEG_7       = 7'h0F;
  localparam logic [6:0] SEG_8       = 7'h00;
  localparam logic [6:0] SEG_9       = 7'h04;
  localparam logic [6:0] SEG_NULL    = 7'h7F;
  localparam logic [6:0] SEG_PARK    = 7'h18;
  localparam logic [6:0] SEG_DRIVE   = 7'h42;
  localparam logic [6:0] SEG_REVERSE = 7'h39;
  localparam logic [6:0] SEG_LEFT    = 7'h71;
  localparam logic [6:0] SEG_RIGHT   = 7'h39;
  localparam logic [6:0] SEG_FORWARD = 7'h38;
  localparam logic [6:0] SEG_BRAKE   = 7'h60;

  typedef enum logic [4:0] {
    SYM_0     = 5'd0,
    SYM_1     = 5'd1,
    SYM_2     = 5'd2,
    SYM_3     = 5'd3,
    SYM_4     = 5'd4,
    SYM_5     = 5'd5,
    SYM_6     = 5'd6,
    SYM_7     = 5'd7,
    SYM_8     = 5'd8,
    SYM_9     = 5'd9,
    SYM_BLANK = 5'd10,
    SYM_P     = 5'd11,
    SYM_D     = 5'd12,
    SYM_R     = 5'd13,
    SYM_L     = 5'd14,
    SYM_F     = 5'd15,
    SYM_B     = 5'd16,
    SYM_ERR   = 5'd31
  } sym_t;

  function automatic logic an_onehot_low(input logic [7:0] an);
    return ($countones(~an) == 32'd1);
  endfunction

  function automatic logic [2:0] an_slot(input logic [7:0] an);
    logic [2:0] slot;
    slot = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) slot = 3'(i);
      else        slot = slot;
    end
    return slot;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-low 7-segment pattern to its symbol code;
// unrecognised patterns decode to SYM_ERR.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output sym_t       sym
);

  // Pattern lookup; RIGHT shares the REVERSE pattern and decodes to R.
  always_comb begin
    sym = SYM_ERR;
    case (pattern)
      SEG_0:       sym = SYM_0;
      SEG_1:       sym = SYM_1;
      SEG_2:       sym = SYM_2;
      SEG_3:       sym = SYM_3;
      SEG_4:       sym = SYM_4;
      SEG_5:       sym = SYM_5;
      SEG_6:       sym = SYM_6;
      SEG_7:       sym = SYM_7;
      SEG_8:       sym = SYM_8;
      SEG_9:       sym = SYM_9;
      SEG_NULL:    sym = SYM_BLANK;
      SEG_PARK:    sym = SYM_P;
      SEG_DRIVE:   sym = SYM_D;
      SEG_REVERSE: sym = SYM_R;
      SEG_LEFT:    sym = SYM_L;
      SEG_FORWARD: sym = SYM_F;
      SEG_BRAKE:   sym = SYM_B;
      default:     sym = SYM_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers 8-digit frames from a multiplexed active-low 7-segment bus and offers
// them on valid/ready. Optional macro SEG7_DP_CAPTURE_EN enables per-digit dp capture.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk100mhz,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        dp_in,
  input  logic [7:0]  an_in,
  input  logic        frame_ready,
  input  logic        clear_flags,
  output logic        frame_valid,
  output logic [39:0] frame_sym,
  output logic [7:0]  frame_dp,
  output logic        overrun,
  output logic        an_error
);

  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  logic             dp_raw_s;
  logic [15:0]      sync_r [NSYNC];
  logic [15:0]      cur_s;
  logic [15:0]      prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;
  logic             change_s;
  logic             settled_s;
  logic             capture_s;
  logic             bad_an_s;
  logic             complete_s;
  logic             load_s;
  logic [2:0]       slot_s;
  sym_t             sym_s;
  logic [7:0]       seen_r;
  logic [39:0]      shadow_sym_r;

`ifdef SEG7_DP_CAPTURE_EN
  assign dp_raw_s = dp_in;
`else
  // dp held inactive so it never disturbs stability tracking
  assign dp_raw_s = dp_in | 1'b1;
`endif

  // Input synchronizer chain; idles at the all-off (all ones) level.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSYNC; i++) sync_r[i] <= 16'hFFFF;
    end else begin
      sync_r[0] <= {an_in, seg_in, dp_raw_s};
      for (int i = 1; i < NSYNC; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign cur_s      = sync_r[NSYNC-1];
  assign change_s   = (cur_s != prev_r);
  assign settled_s  = (cnt_r == CNT_MAX) && !done_r && !change_s;
  assign capture_s  = settled_s && an_onehot_low(cur_s[15:8]);
  assign bad_an_s   = settled_s && !an_onehot_low(cur_s[15:8]);
  assign slot_s     = an_slot(cur_s[15:8]);
  assign complete_s = (seen_r == 8'hFF);
  assign load_s     = complete_s && (!frame_valid || frame_ready);

  seg7_pattern_decode u_decode (
    .pattern (cur_s[7:1]),
    .sym     (sym_s)
  );

  // Stability tracker: one capture opportunity per settled dwell.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      prev_r <= 16'hFFFF;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else begin
      prev_r <= cur_s;
      if (change_s) begin
        cnt_r  <= '0;
        done_r <= 1'b0;
      end else begin
        if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
        else                  cnt_r <= cnt_r;
        done_r <= done_r | settled_s;
      end
    end
  end

  // Shadow frame and seen mask; a completing frame clears the mask before new captures land.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      seen_r       <= 8'h00;
      shadow_sym_r <= '0;
    end else begin
      if (capture_s) begin
        shadow_sym_r[SYM_W*int'(slot_s) +: SYM_W] <= sym_s;
        seen_r <= (complete_s ? 8'h00 : seen_r) | (8'h01 << slot_s);
      end else begin
        seen_r <= complete_s ? 8'h00 : seen_r;
      end
    end
  end

  // Output frame register, handshake and sticky flags (set beats clear).
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_sym   <= 40'h0;
      overrun     <= 1'b0;
      an_error    <= 1'b0;
    end else begin
      if (load_s) begin
        frame_valid <= 1'b1;
        frame_sym   <= shadow_sym_r;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end else begin
        frame_valid <= frame_valid;
      end
      overrun  <= (complete_s && !load_s) | (overrun & ~clear_flags);
      an_error <= bad_an_s | (an_error & ~clear_flags);
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  logic [7:0] shadow_dp_r;

  // Per-digit decimal point capture, loaded alongside the symbols.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      shadow_dp_r <= 8'hFF;
      frame_dp    <= 8'hFF;
    end else begin
      if (capture_s) shadow_dp_r[slot_s] <= cur_s[0];
      else           shadow_dp_r <= shadow_dp_r;
      if (load_s)    frame_dp <= shadow_dp_r;
      else           frame_dp <= frame_dp;
    end
  end
`else
  assign frame_dp = 8'hFF;
`endif

endmodule
